fetch_seq: RTL and testbench



---
 rtl/fetch_seq_pkg.sv | 38 +++
 rtl/fetch_seq_ret_stack.sv | 50 +++++
 rtl/fetch_seq.sv | 167 ++++++++++++++++
 tb/tb_fetch_seq.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared types and defaults for the fetch sequencer: jump conditions,
// sequencer states and the branch-condition helper.
package fetch_seq_pkg;

  localparam int AW_DEFAULT          = 8;
  localparam int IW_DEFAULT          = 16;
  localparam int STACK_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    JMP = 2'b00,
    JZ  = 2'b01,
    JNZ = 2'b10,
    JL  = 2'b11
  } jump_t;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    EXEC,
    HALT
  } seq_state_t;

  // Branch decision from the flags held before the current instruction.
  // JL is signed less-than, i.e. sign differs from overflow.
  function automatic logic cond_met(jump_t cond, logic z, logic s, logic o);
    logic taken;
    taken = 1'b0;
    case (cond)
      JMP:     taken = 1'b1;
      JZ:      taken = z;
      JNZ:     taken = !z;
      JL:      taken = (s != o);
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/fetch_seq_ret_stack.sv
// ret_stack: small LIFO of return addresses for the call/return option.
// Overflowing pushes and underflowing pops are ignored here; the sequencer
// decides what an illegal access means.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] data,
  output logic         full,
  output logic         empty
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]    mem [DEPTH];
  logic [CW-1:0]   count;
  logic [IDXW-1:0] wr_idx;
  logic [IDXW-1:0] rd_idx;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign wr_idx = IDXW'(count);
  assign rd_idx = IDXW'(count - 1'b1);
  assign data   = mem[rd_idx];

  // Occupancy counter; reset empties the stack.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + 1'b1;
    end else if (pop && !empty) begin
      count <= count - 1'b1;
    end
  end

  // Entry storage; contents need no reset because occupancy guards reads.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: multi-cycle instruction sequencer. Owns the PC, the
// instruction-memory handshake, the Z/S/O flags and branch resolution.
// Optional feature macro: FETCH_SEQ_CALL_STACK_EN (adds call/return stack).
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int IW = IW_DEFAULT
`ifdef FETCH_SEQ_CALL_STACK_EN
  ,
  parameter int STACK_DEPTH = STACK_DEPTH_DEFAULT
`endif
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_valid,
  input  logic [IW-1:0] imem_data,
  output logic          instr_valid,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] pc,
  input  logic          exec_done,
  input  logic          is_jump,
  input  jump_t         jump_cond,
  input  logic [AW-1:0] jump_addr,
  input  logic          is_halt,
  input  logic          flag_we,
  input  logic          z_in,
  input  logic          s_in,
  input  logic          o_in,
`ifdef FETCH_SEQ_CALL_STACK_EN
  input  logic          is_call,
  input  logic          is_ret,
  output logic          stack_err,
`endif
  output logic          halted
);

  seq_state_t    state;
  seq_state_t    state_next;
  logic [AW-1:0] pc_next;
  logic [AW-1:0] pc_inc;
  logic          capture;
  logic          flag_upd;
  logic          z_q;
  logic          s_q;
  logic          o_q;

`ifdef FETCH_SEQ_CALL_STACK_EN
  logic          push;
  logic          pop;
  logic          err_set;
  logic [AW-1:0] stack_top;
  logic          stack_full;
  logic          stack_empty;

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (AW)
  ) u_ret_stack (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (pc_inc),
    .data    (stack_top),
    .full    (stack_full),
    .empty   (stack_empty)
  );
`endif

  assign pc_inc      = pc + AW'(1);
  assign imem_addr   = pc;
  assign imem_req    = (state == FETCH) || (state == WAIT);
  assign instr_valid = (state == EXEC);
  assign halted      = (state == HALT);

  // Next state and next PC; control inputs matter only on exec_done in EXEC.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    capture    = 1'b0;
    flag_upd   = 1'b0;
`ifdef FETCH_SEQ_CALL_STACK_EN
    push       = 1'b0;
    pop        = 1'b0;
    err_set    = 1'b0;
`endif
    case (state)
      FETCH: state_next = WAIT;
      WAIT: begin
        if (imem_valid) begin
          capture    = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (exec_done) begin
          flag_upd   = flag_we;
          state_next = FETCH;
          if (is_halt) begin
            state_next = HALT;
          end
`ifdef FETCH_SEQ_CALL_STACK_EN
          else if (is_call) begin
            if (stack_full) begin
              err_set    = 1'b1;
              state_next = HALT;
            end else begin
              push    = 1'b1;
              pc_next = jump_addr;
            end
          end else if (is_ret) begin
            if (stack_empty) begin
              err_set    = 1'b1;
              state_next = HALT;
            end else begin
              pop     = 1'b1;
              pc_next = stack_top;
            end
          end
`endif
          else if (is_jump && cond_met(jump_cond, z_q, s_q, o_q)) begin
            pc_next = jump_addr;
          end else begin
            pc_next = pc_inc;
          end
        end
      end
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  // Architectural registers: state, PC, captured instruction and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= '0;
      instr <= '0;
      z_q   <= 1'b0;
      s_q   <= 1'b0;
      o_q   <= 1'b0;
`ifdef FETCH_SEQ_CALL_STACK_EN
      stack_err <= 1'b0;
`endif
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (capture) begin
        instr <= imem_data;
      end
      if (flag_upd) begin
        z_q <= z_in;
        s_q <= s_in;
        o_q <= o_in;
      end
`ifdef FETCH_SEQ_CALL_STACK_EN
      if (err_set) begin
        stack_err <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Testbench for fetch_seq: directed instruction sequences against an
// instruction-level model of PC, flags, halt and return stack.
module tb_fetch_seq;
  import fetch_seq_pkg::*;

  localparam int AW    = 8;
  localparam int IW    = 16;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic          jmp;
    jump_t         cond;
    logic [AW-1:0] addr;
    logic          halt;
    logic          fwe;
    logic          z;
    logic          s;
    logic          o;
    logic          call;
    logic          ret;
  } ctl_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_valid = 1'b0;
  logic [IW-1:0] imem_data = '0;
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic [AW-1:0] pc;
  logic          exec_done = 1'b0;
  logic          is_jump = 1'b0;
  jump_t         jump_cond = JMP;
  logic [AW-1:0] jump_addr = '0;
  logic          is_halt = 1'b0;
  logic          flag_we = 1'b0;
  logic          z_in = 1'b0;
  logic          s_in = 1'b0;
  logic          o_in = 1'b0;
  logic          halted;
`ifdef FETCH_SEQ_CALL_STACK_EN
  logic          is_call = 1'b0;
  logic          is_ret = 1'b0;
  logic          stack_err;
`endif

  logic [IW-1:0] mem [256];

  logic [AW-1:0] m_pc = '0;
  logic          m_z = 1'b0;
  logic          m_s = 1'b0;
  logic          m_o = 1'b0;
  logic          m_halted = 1'b0;
  logic          m_err = 1'b0;
  logic [IW-1:0] m_instr = '0;
  logic [AW-1:0] m_stack [$];
  logic          e_req = 1'b1;
  logic          e_valid = 1'b0;
  logic          chk_en = 1'b0;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  fetch_seq #(
    .AW (AW),
    .IW (IW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_data   (imem_data),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .exec_done   (exec_done),
    .is_jump     (is_jump),
    .jump_cond   (jump_cond),
    .jump_addr   (jump_addr),
    .is_halt     (is_halt),
    .flag_we     (flag_we),
    .z_in        (z_in),
    .s_in        (s_in),
    .o_in        (o_in),
`ifdef FETCH_SEQ_CALL_STACK_EN
    .is_call     (is_call),
    .is_ret      (is_ret),
    .stack_err   (stack_err),
`endif
    .halted      (halted)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to measure instruction latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Every-cycle comparison of the DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("imem_req", 32'(imem_req), 32'(e_req));
      checkOutput("instr_valid", 32'(instr_valid), 32'(e_valid));
      checkOutput("halted", 32'(halted), 32'(m_halted));
      checkOutput("pc", 32'(pc), 32'(m_pc));
      checkOutput("imem_addr", 32'(imem_addr), 32'(m_pc));
      if (e_valid) checkOutput("instr", 32'(instr), 32'(m_instr));
`ifdef FETCH_SEQ_CALL_STACK_EN
      checkOutput("stack_err", 32'(stack_err), 32'(m_err));
`endif
    end
  end

  function automatic ctl_t nj(logic fwe, logic z, logic s, logic o);
    ctl_t c;
    c = '0;
    c.fwe = fwe; c.z = z; c.s = s; c.o = o;
    return c;
  endfunction

  function automatic ctl_t jp(jump_t cond, logic [AW-1:0] addr);
    ctl_t c;
    c = '0;
    c.jmp = 1'b1; c.cond = cond; c.addr = addr;
    return c;
  endfunction

  task automatic driveCtl(input ctl_t c);
    is_jump = c.jmp; jump_cond = c.cond; jump_addr = c.addr; is_halt = c.halt;
    flag_we = c.fwe; z_in = c.z; s_in = c.s; o_in = c.o;
`ifdef FETCH_SEQ_CALL_STACK_EN
    is_call = c.call; is_ret = c.ret;
`endif
  endtask

  // Controls that must be ignored whenever exec_done is not accepted.
  task automatic driveGarbage();
    ctl_t c;
    c = '0;
    c.jmp = 1'b1; c.cond = JMP; c.addr = 8'h99; c.halt = 1'b1;
    c.fwe = 1'b1; c.z = 1'b1; c.s = 1'b1;
    c.call = 1'b1; c.ret = 1'b1;
    driveCtl(c);
  endtask

  // Instruction-level effect of one completed instruction.
  task automatic modelRetire(input ctl_t c);
    logic [AW-1:0] nxt;
    logic taken;
    nxt = m_pc + 8'd1;
    taken = 1'b0;
    if (c.halt) begin
      m_halted = 1'b1;
    end
`ifdef FETCH_SEQ_CALL_STACK_EN
    else if (c.call) begin
      if (m_stack.size() == DEPTH) begin m_err = 1'b1; m_halted = 1'b1; end
      else begin m_stack.push_back(nxt); m_pc = c.addr; end
    end else if (c.ret) begin
      if (m_stack.size() == 0) begin m_err = 1'b1; m_halted = 1'b1; end
      else m_pc = m_stack.pop_back();
    end
`endif
    else begin
      if (c.jmp) begin
        case (c.cond)
          JMP: taken = 1'b1;
          JZ:  taken = m_z;
          JNZ: taken = !m_z;
          JL:  taken = (m_s != m_o);
          default: taken = 1'b0;
        endcase
      end
      m_pc = taken ? c.addr : nxt;
    end
    if (c.fwe) begin m_z = c.z; m_s = c.s; m_o = c.o; end
  endtask

  task automatic applyReset();
    chk_en = 1'b0;
    rst = 1'b1; imem_valid = 1'b0; exec_done = 1'b0;
    driveCtl('0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_pc = '0; m_z = 1'b0; m_s = 1'b0; m_o = 1'b0;
    m_halted = 1'b0; m_err = 1'b0; m_stack.delete();
    e_req = 1'b1; e_valid = 1'b0;
    chk_en = 1'b1;
  endtask

  // One instruction: memory latency lat extra cycles, execute takes edelay extra cycles.
  task automatic applyStimulus(input int lat, input int edelay, input ctl_t c);
    e_req = 1'b1; e_valid = 1'b0;
    imem_valid = 1'b1; imem_data = 16'hBAD0;
    exec_done = 1'b1; driveGarbage();
    @(posedge clk); #1;
    imem_valid = 1'b0; imem_data = 16'h0BAD;
    repeat (lat) begin @(posedge clk); #1; end
    imem_valid = 1'b1; imem_data = mem[m_pc];
    @(posedge clk); #1;
    imem_valid = 1'b0;
    m_instr = mem[m_pc];
    e_req = 1'b0; e_valid = 1'b1;
    exec_done = 1'b0;
    repeat (edelay) begin @(posedge clk); #1; end
    driveCtl(c); exec_done = 1'b1;
    @(posedge clk); #1;
    exec_done = 1'b0; driveGarbage();
    modelRetire(c);
    e_valid = 1'b0;
    e_req = !m_halted;
  endtask

  initial begin
    int c0;
    ctl_t c;
    for (int i = 0; i < 256; i++) mem[i] = {8'(i) ^ 8'hA5, 8'(i)};

    $display("[TB] reset and sequential fetch");
    applyReset();
    #2;
    checkOutput("rst_pc", 32'(pc), 32'h0);
    checkOutput("rst_req", 32'(imem_req), 32'h1);
    checkOutput("rst_instr_valid", 32'(instr_valid), 32'h0);
    checkOutput("rst_instr", 32'(instr), 32'h0);
    checkOutput("rst_halted", 32'(halted), 32'h0);

    c0 = cyc;
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, nj(0, 0, 0, 0));
    checkOutput("seq_cycles", 32'(cyc - c0), 32'd9);
    checkOutput("seq_pc", 32'(pc), 32'h3);

    $display("[TB] flag timing and branches");
    c = jp(JZ, 8'h40); c.fwe = 1'b1; c.z = 1'b1;
    applyStimulus(0, 0, c);
    checkOutput("jz_old_flag", 32'(pc), 32'h4);
    applyStimulus(1, 0, jp(JZ, 8'h40));
    checkOutput("jz_taken", 32'(pc), 32'h40);
    applyStimulus(0, 2, nj(1, 0, 1, 0));
    applyStimulus(0, 0, jp(JL, 8'h20));
    checkOutput("jl_taken", 32'(pc), 32'h20);
    applyStimulus(0, 0, nj(1, 0, 1, 1));
    applyStimulus(0, 0, jp(JL, 8'h20));
    checkOutput("jl_not_taken", 32'(pc), 32'h22);
    applyStimulus(0, 0, jp(JNZ, 8'h80));
    checkOutput("jnz_taken", 32'(pc), 32'h80);
    applyStimulus(0, 0, jp(JMP, 8'hFF));

    $display("[TB] pc wrap");
    applyStimulus(2, 1, nj(0, 0, 0, 0));
    #2;
    checkOutput("wrap_pc", 32'(pc), 32'h0);
    checkOutput("wrap_addr", 32'(imem_addr), 32'h0);
    applyStimulus(0, 0, nj(1, 1, 0, 0));

    $display("[TB] reset during wait with stale data");
    e_req = 1'b1; imem_valid = 1'b0;
    @(posedge clk); #1;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_pc = '0; m_z = 1'b0; m_s = 1'b0; m_o = 1'b0;
    imem_valid = 1'b1; imem_data = 16'hDEAD;
    #2;
    checkOutput("rstw_pc", 32'(pc), 32'h0);
    checkOutput("rstw_instr_valid", 32'(instr_valid), 32'h0);
    @(posedge clk); #1;
    imem_valid = 1'b0;
    #2;
    checkOutput("stale_instr", 32'(instr), 32'h0);
    checkOutput("stale_valid", 32'(instr_valid), 32'h0);
    checkOutput("stale_req", 32'(imem_req), 32'h1);

    applyReset();
    applyStimulus(0, 0, jp(JZ, 8'h30));
    checkOutput("flags_reset", 32'(pc), 32'h1);
    applyStimulus(0, 0, jp(JMP, 8'h05));

    $display("[TB] halt");
    c = jp(JMP, 8'h77); c.halt = 1'b1;
    applyStimulus(0, 0, c);
    for (int i = 0; i < 10; i++) begin
      imem_valid = 1'b1; imem_data = 16'h1234; exec_done = 1'b1;
      @(posedge clk); #1;
    end
    imem_valid = 1'b0; exec_done = 1'b0;
    #2;
    checkOutput("halt_pc", 32'(pc), 32'h5);
    checkOutput("halt_flag", 32'(halted), 32'h1);
    checkOutput("halt_req", 32'(imem_req), 32'h0);

`ifdef FETCH_SEQ_CALL_STACK_EN
    $display("[TB] call stack");
    applyReset();
    c = '0; c.call = 1'b1; c.addr = 8'h10;
    applyStimulus(0, 0, c);
    c = '0; c.ret = 1'b1;
    applyStimulus(0, 0, c);
    checkOutput("ret_pc", 32'(pc), 32'h1);
    c = '0; c.call = 1'b1; c.addr = 8'h10;
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, c);
    #2;
    checkOutput("stack_err", 32'(stack_err), 32'h1);
    checkOutput("stack_halted", 32'(halted), 32'h1);
    checkOutput("stack_pc", 32'(pc), 32'h10);
`endif

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
